// File: rtl/mem_copy_if.sv
// Control and memory-bus bundle for mem_copy_engine.
// The master modport is the engine side; slave is the controller/memory side.
interface mem_copy_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  modport master (
    input  start, src, dst, len, mem_rd,
    output busy, done, mem_we, mem_a, mem_wd
  );

  modport slave (
    output start, src, dst, len, mem_rd,
    input  busy, done, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-move engine: copies len words from src to dst in ascending order,
// one read cycle then one write cycle per word, on a single-port memory.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  mem_copy_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q,   src_d;
  logic [31:0]      dst_q,   dst_d;
  logic [31:0]      data_q,  data_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      cnt_off;

  // Synchronous reset clears every register; the engine is small enough that
  // clearing the data holding register too costs nothing and keeps mem_wd defined.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Termination compares against len_q-1, so cnt_q never has to reach len_q.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a latch behind.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d   = bus.src & 32'hFFFF_FFFC;
          dst_d   = bus.dst & 32'hFFFF_FFFC;
          len_d   = bus.len;
          cnt_d   = '0;
          state_d = (bus.len != '0) ? READ : DONE;
        end
      end
      READ: begin
        data_d  = bus.mem_rd;
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = READ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cnt_off = 32'(cnt_q) << 2;

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    unique case (state_q)
      READ: begin
        bus.busy  = 1'b1;
        bus.mem_a = src_q + cnt_off;
      end
      WRITE: begin
        bus.busy   = 1'b1;
        bus.mem_we = 1'b1;
        bus.mem_a  = dst_q + cnt_off;
        bus.mem_wd = data_q;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level copy model predicts reads,
// writes and done timing; a negedge monitor compares whatever the engine presents.
module tb_mem_copy_engine;

  localparam int LEN_W = 16;
  localparam int MEM_WORDS = 256;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int cyc;
    int busy_cycles;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  mem_copy_if #(.LEN_W(LEN_W)) bus ();

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, write at the rising edge; 1 KB image that
  // aliases the 32-bit address space, so wrapped addresses land consistently.
  logic [31:0] mem [MEM_WORDS];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;

  assign bus.mem_rd = mem[bus.mem_a[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (bus.mem_we) mem[bus.mem_a[9:2]] <= bus.mem_wd;
  end

  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  bit sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read cycle, write cycle and done pulse pops one expectation.
  always @(negedge clk) begin
    if (!sb_en || reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.mem_we && !bus.busy) check("we_outside_busy", 32'(bus.busy), 32'd1);
      if (bus.busy && !bus.mem_we) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(exp_rd.size()), 32'd1);
        else check("rd_addr", bus.mem_a, exp_rd.pop_front());
      end
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", bus.mem_a, w.a);
          check("wr_data", bus.mem_wd, w.d);
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(exp_done.size()), 32'd1);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  // Reference: an ascending word-by-word copy on the model memory, with the
  // engine's timing rule of 2N busy cycles and done 2N edges after acceptance.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int start_cyc);
    logic [31:0] s, d, ra, wa, data;
    done_t dn;
    s = src & ~32'd3;
    d = dst & ~32'd3;
    for (int i = 0; i < len; i++) begin
      ra = s + 32'(4 * i);
      wa = d + 32'(4 * i);
      data = ref_mem[ra[9:2]];
      ref_mem[wa[9:2]] = data;
      exp_rd.push_back(ra);
      exp_wr.push_back('{a: wa, d: data});
    end
    dn.cyc = start_cyc + 2 * len;
    dn.busy_cycles = 2 * len;
    exp_done.push_back(dn);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = 8'(idx);
    ld_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_rd.size() + exp_wr.size() + exp_done.size()), 32'd0);
  endtask

  // One copy; with glitch set, a start pulse with other operands lands mid-copy.
  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst,
                         input int len, input bit glitch);
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = src;
    bus.dst   = dst;
    bus.len   = LEN_W'(len);
    model_copy(src, dst, len, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.src   = $urandom;
    bus.dst   = $urandom;
    bus.len   = LEN_W'($urandom_range(1, 9));
    if (glitch && len > 0) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    repeat (2 * len + 4) @(negedge clk);
    check_drained("copy_drained");
  endtask

  initial begin
    int e;
    logic [31:0] old_w [6];
    logic [31:0] src_w [6];
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_a",  bus.mem_a,       32'd0);
    check("rst_mem_wd", bus.mem_wd,      32'd0);
    reset = 1'b0;

    for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);
    sb_en = 1'b1;

    // Basic copy of eight recognisable words.
    for (int i = 0; i < 8; i++) poke(i, 32'h1111_1111 * 32'(i + 1));
    do_copy(32'h0, 32'h40, 8, 1'b0);

    // Zero length: only a done pulse the cycle after acceptance.
    do_copy(32'h10, 32'h20, 0, 1'b0);

    // Unaligned operands, plus an ignored start while busy.
    do_copy(32'h13, 32'h22, 2, 1'b1);

    // Overlapping copies, downward then upward.
    for (int i = 0; i < 4; i++) poke(i, 32'hA0 + 32'(i));
    do_copy(32'h4, 32'h0, 3, 1'b0);
    for (int i = 0; i < 4; i++) poke(i, 32'hA0 + 32'(i));
    do_copy(32'h0, 32'h4, 3, 1'b0);

    // Address wrap past the top of the 32-bit space.
    do_copy(32'hFFFF_FFF8, 32'h200, 4, 1'b0);

    // Randomised copies.
    for (int k = 0; k < 24; k++)
      do_copy($urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 12), 1'($urandom_range(0, 1)));

    // Back-to-back: start held high with len=1 gives a copy every 4 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = 32'h80;
    bus.dst   = 32'h300;
    bus.len   = LEN_W'(1);
    e = cyc + 1;
    for (int k = 0; k < 5; k++) model_copy(32'h80, 32'h300, 1, e + 4 * k);
    while (cyc < e + 16) @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check_drained("b2b_drained");

    // Reset in the WRITE cycle of word 2 of a six-word copy.
    sb_en = 1'b0;
    for (int i = 0; i < 6; i++) poke(64 + i, ~ref_mem[i]);
    for (int i = 0; i < 6; i++) begin
      old_w[i] = ref_mem[64 + i];
      src_w[i] = ref_mem[i];
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.src   = 32'h0;
    bus.dst   = 32'h100;
    bus.len   = LEN_W'(6);
    e = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    check("pre_rst_in_write", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_mem_a",  bus.mem_a,       32'd0);
    check("midrst_word0", mem[64], src_w[0]);
    check("midrst_word1", mem[65], src_w[1]);
    check("midrst_word2_ok", 32'(mem[66] === old_w[2] || mem[66] === src_w[2]), 32'd1);
    for (int i = 3; i < 6; i++) check($sformatf("midrst_word%0d", i), mem[64 + i], old_w[i]);
    ref_mem[64] = src_w[0];
    ref_mem[65] = src_w[1];
    ref_mem[66] = mem[66];
    sb_en = 1'b1;
    repeat (4) @(negedge clk);
    check_drained("midrst_quiet");

    // Normal operation resumes after the reset.
    do_copy(32'h0, 32'h100, 6, 1'b0);

    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
